// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in parallel-out deserializer.
// Holds the default word width, the counter-width helper and the delivery decision type.
package sipo_pkg;

  localparam int SIPO_WIDTH_DEFAULT = 32'sd10;

  // Outcome of a strobe cycle for the holding register
  typedef enum logic [1:0] {
    DLV_NONE = 2'd0,
    DLV_LOAD = 2'd1,
    DLV_DROP = 2'd2
  } dlv_e;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 32'sd0; i < 32'sd31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 32'sd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, parallel output and status bundle of the deserializer.
// The slave modport is the deserializer's view; master is the surrounding logic.
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
);

  logic             si;
  logic             si_valid;
  logic             sync;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             so;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    output si, si_valid, sync, po_ready, ovr_clr,
    input  po, po_valid, so, overrun
  );

  modport slave (
    input  si, si_valid, sync, po_ready, ovr_clr,
    output po, po_valid, so, overrun
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// MSB-first shift register: new bits enter at bit 0, the oldest bit leaves on so.
// Clear is synchronous and active-low and takes priority over the shift enable.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ce,
  input  logic             din,
  output logic [WIDTH-1:0] sr,
  output logic             so
);

  logic [WIDTH-1:0] sr_r;

  // Shift register state: clear, shift on enable, otherwise hold
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sr_r <= '0;
    end else if (ce) begin
      sr_r <= {sr_r[WIDTH-2:0], din};
    end else begin
      sr_r <= sr_r;
    end
  end

  assign sr = sr_r;
  assign so = sr_r[WIDTH-1];

endmodule

// File: rtl/sipo_deserializer.sv
// Deserializer top: counts strobes, detects word completion and manages the
// holding register with its valid/ready handshake and sticky overrun flag.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
  input logic                 clk,
  input logic                 resetn,
  sipo_deserializer_if.slave  bus
);

  localparam int             CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'sd0);

  logic [WIDTH-1:0] sr_s;
  logic             so_s;
  logic             unused_msb_s;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] po_r;
  logic [WIDTH-1:0] po_nxt_s;
  logic             po_valid_r;
  logic             po_valid_nxt_s;
  logic             overrun_r;
  logic             overrun_nxt_s;
  logic             complete_s;
  logic [WIDTH-1:0] word_s;
  dlv_e             dlv_s;

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk   (clk),
    .clr_n (resetn),
    .ce    (bus.si_valid),
    .din   (bus.si),
    .sr    (sr_s),
    .so    (so_s)
  );

  // The MSB leaves the block through so; the word only needs the lower bits
  assign unused_msb_s = sr_s[WIDTH-1];

  // Completion detection, counter next-state and holding-register decisions
  always_comb begin
    complete_s     = 1'b0;
    word_s         = {sr_s[WIDTH-2:0], bus.si};
    dlv_s          = DLV_NONE;
    cnt_nxt_s      = cnt_r;
    po_nxt_s       = po_r;
    po_valid_nxt_s = po_valid_r;
    overrun_nxt_s  = overrun_r;

    if (bus.si_valid && !bus.sync && (cnt_r == CNT_LAST)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end

    // A sync strobe starts a fresh word; sync alone just rewinds the count
    if (bus.sync) begin
      if (bus.si_valid) begin
        cnt_nxt_s = CNT_ONE;
      end else begin
        cnt_nxt_s = CNT_ZERO;
      end
    end else if (bus.si_valid) begin
      if (complete_s) begin
        cnt_nxt_s = CNT_ZERO;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end

    if (complete_s) begin
      if (!po_valid_r || bus.po_ready) begin
        dlv_s = DLV_LOAD;
      end else begin
        dlv_s = DLV_DROP;
      end
    end else begin
      dlv_s = DLV_NONE;
    end

    case (dlv_s)
      DLV_LOAD: begin
        po_nxt_s       = word_s;
        po_valid_nxt_s = 1'b1;
      end
      DLV_DROP: begin
        po_valid_nxt_s = 1'b1;
      end
      DLV_NONE: begin
        if (po_valid_r && bus.po_ready) begin
          po_valid_nxt_s = 1'b0;
        end else begin
          po_valid_nxt_s = po_valid_r;
        end
      end
      default: begin
        po_nxt_s       = po_r;
        po_valid_nxt_s = po_valid_r;
      end
    endcase

    // A drop in the same cycle as a clear leaves the flag set
    if (dlv_s == DLV_DROP) begin
      overrun_nxt_s = 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_nxt_s = 1'b0;
    end else begin
      overrun_nxt_s = overrun_r;
    end
  end

  // Counter, holding register and status flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r      <= CNT_ZERO;
      po_r       <= '0;
      po_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      po_r       <= po_nxt_s;
      po_valid_r <= po_valid_nxt_s;
      overrun_r  <= overrun_nxt_s;
    end
  end

  assign bus.po       = po_r;
  assign bus.po_valid = po_valid_r;
  assign bus.overrun  = overrun_r;
  assign bus.so       = so_s;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer (WIDTH=10): expected words are queued
// as they are serialized and checked when the handshake consumes them.
module tb_sipo_deserializer;
  import sipo_pkg::*;

  localparam int W = 10;

  logic clk = 1'b0;
  logic resetn;
  int   check_cnt = 0;
  int   err_cnt   = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(W)) bus ();

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every accepted handshake must match the oldest queued word
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.po_valid === 1'b1 && bus.po_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        check_val("sb_word", 32'(bus.po), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serialize bits[n-1:0] MSB first, as a PISO loaded with them would
  task automatic send_bits(input logic [W-1:0] bits, input int n, input bit ready_on_last,
                           input bit chk_idle, input bit gaps);
    logic [W-1:0] piso;
    piso = bits << (W - n);
    for (int i = 0; i < n; i++) begin
      bus.si       = piso[W-1];
      piso         = {piso[W-2:0], 1'b0};
      bus.si_valid = 1'b1;
      if (i == n - 1) bus.po_ready = ready_on_last;
      tick();
      bus.si_valid = 1'b0;
      bus.po_ready = 1'b0;
      if (chk_idle && i < n - 1) check_val("no_early_valid", 32'(bus.po_valid), 32'd0);
      if (gaps) begin
        bus.si = 1'($urandom);
        repeat ($urandom_range(0, 3)) tick();
      end
    end
  endtask

  task automatic consume();
    bus.po_ready = 1'b1;
    tick();
    bus.po_ready = 1'b0;
    check_val("valid_cleared", 32'(bus.po_valid), 32'd0);
  endtask

  task automatic deliver(input logic [W-1:0] word);
    exp_q.push_back(word);
    send_bits(word, W, 1'b0, 1'b0, 1'b0);
    check_val("valid_after_word", 32'(bus.po_valid), 32'd1);
    check_val("po_word", 32'(bus.po), 32'(word));
    consume();
  endtask

  initial begin
    logic [W-1:0] rt [4];
    rt = '{10'h155, 10'h3FF, 10'h000, 10'h201};

    resetn       = 1'b0;
    bus.si       = 1'b1;
    bus.si_valid = 1'b1;
    bus.sync     = 1'b0;
    bus.po_ready = 1'b0;
    bus.ovr_clr  = 1'b0;
    tick();
    tick();
    check_val("rst_po", 32'(bus.po), 32'd0);
    check_val("rst_valid", 32'(bus.po_valid), 32'd0);
    check_val("rst_overrun", 32'(bus.overrun), 32'd0);
    check_val("rst_so", 32'(bus.so), 32'd0);
    check_val("rst_cnt", 32'(dut.cnt_r), 32'd0);
    resetn       = 1'b1;
    bus.si_valid = 1'b0;
    bus.si       = 1'b0;
    tick();

    // Single word held until consumed
    exp_q.push_back(10'h2CE);
    send_bits(10'h2CE, W, 1'b0, 1'b1, 1'b0);
    check_val("single_valid", 32'(bus.po_valid), 32'd1);
    check_val("single_po", 32'(bus.po), 32'h2CE);
    check_val("single_so", 32'(bus.so), 32'd1);
    repeat (3) tick();
    check_val("hold_valid", 32'(bus.po_valid), 32'd1);
    check_val("hold_po", 32'(bus.po), 32'h2CE);
    consume();
    check_val("po_kept", 32'(bus.po), 32'h2CE);

    // Round trips
    for (int k = 0; k < 4; k++) deliver(rt[k]);

    // Overrun: second word dropped, first kept
    exp_q.push_back(10'h0AA);
    send_bits(10'h0AA, W, 1'b0, 1'b0, 1'b0);
    send_bits(10'h155, W, 1'b0, 1'b0, 1'b0);
    check_val("ovr_po", 32'(bus.po), 32'h0AA);
    check_val("ovr_flag", 32'(bus.overrun), 32'd1);
    check_val("ovr_valid", 32'(bus.po_valid), 32'd1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check_val("ovr_cleared", 32'(bus.overrun), 32'd0);
    consume();

    // Overrun coinciding with a clear keeps the flag set
    exp_q.push_back(10'h0F0);
    send_bits(10'h0F0, W, 1'b0, 1'b0, 1'b0);
    bus.ovr_clr = 1'b1;
    send_bits(10'h00F, W, 1'b0, 1'b0, 1'b0);
    bus.ovr_clr = 1'b0;
    check_val("ovr_set_wins", 32'(bus.overrun), 32'd1);
    check_val("ovr_set_wins_po", 32'(bus.po), 32'h0F0);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check_val("ovr_cleared2", 32'(bus.overrun), 32'd0);
    consume();

    // Consume and complete in the same cycle
    exp_q.push_back(10'h111);
    send_bits(10'h111, W, 1'b0, 1'b0, 1'b0);
    check_val("b2b_valid1", 32'(bus.po_valid), 32'd1);
    exp_q.push_back(10'h222);
    send_bits(10'h222, W, 1'b1, 1'b0, 1'b0);
    check_val("b2b_valid2", 32'(bus.po_valid), 32'd1);
    check_val("b2b_po", 32'(bus.po), 32'h222);
    check_val("b2b_overrun", 32'(bus.overrun), 32'd0);
    consume();

    // Realign mid-word with a sync strobe carrying the new MSB
    exp_q.push_back(10'h201);
    send_bits(10'h00B, 4, 1'b0, 1'b1, 1'b0);
    bus.sync     = 1'b1;
    bus.si       = 1'b1;
    bus.si_valid = 1'b1;
    tick();
    bus.sync     = 1'b0;
    bus.si_valid = 1'b0;
    check_val("sync_cnt", 32'(dut.cnt_r), 32'd1);
    check_val("sync_no_valid", 32'(bus.po_valid), 32'd0);
    send_bits(10'h001, 9, 1'b0, 1'b1, 1'b0);
    check_val("sync_valid", 32'(bus.po_valid), 32'd1);
    check_val("sync_po", 32'(bus.po), 32'h201);
    consume();

    // Reset mid-word drops the partial word
    send_bits(10'h015, 5, 1'b0, 1'b1, 1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_val("midrst_valid", 32'(bus.po_valid), 32'd0);
    check_val("midrst_cnt", 32'(dut.cnt_r), 32'd0);
    exp_q.push_back(10'h3A5);
    send_bits(10'h3A5, W, 1'b0, 1'b1, 1'b0);
    check_val("midrst_word_valid", 32'(bus.po_valid), 32'd1);
    consume();

    // Strobes with arbitrary gaps
    exp_q.push_back(10'h1B3);
    send_bits(10'h1B3, W, 1'b0, 1'b0, 1'b1);
    check_val("gap_valid", 32'(bus.po_valid), 32'd1);
    check_val("gap_po", 32'(bus.po), 32'h1B3);
    consume();

    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
